// File: rtl/sbm_share_pkg.sv
// Shared types for the multiplier-sharing controller: FSM state encoding and timer width.
package sbm_share_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CLR  = 2'd2
    } state_e;

    localparam int TMR_W = 16;

endpackage

// File: rtl/sbm_share_ctrl_rr_pick.sv
// Combinational round-robin picker: first set request scanning ptr, ptr+1, ... (mod NREQ).
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int IDX_W = $clog2(NREQ);

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input logic [IDX_W-1:0] off);
        logic [IDX_W:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= (IDX_W+1)'(NREQ)) begin
            sum = sum - (IDX_W+1)'(NREQ);
        end
        return sum[IDX_W-1:0];
    endfunction

    logic [IDX_W-1:0] cand [NREQ];
    logic             hit;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        assign cand[gi] = wrap_add(ptr, IDX_W'(gi));
    end

    // Scan from the farthest candidate down so the nearest one to ptr wins.
    always_comb begin
        idx = '0;
        hit = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                idx = cand[k];
                hit = 1'b1;
            end
        end
        grant = hit ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/sbm_share_ctrl.sv
// Round-robin controller sharing one digit-serial multiplier core among NREQ requesters,
// with per-job timeout, one-cycle ack back to the winner and a core clear after each job.
module sbm_share_ctrl
    import sbm_share_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int SIZEA   = 1024,
    parameter int SIZEB   = 1024,
    parameter int TIMEOUT = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*SIZEA-1:0]   a_flat,
    input  logic [NREQ*SIZEB-1:0]   b_flat,
    output logic [NREQ-1:0]         ack,
    output logic [SIZEA+SIZEB-1:0]  res,
    output logic                    res_err,
    output logic                    busy,
    output logic [SIZEA-1:0]        core_a,
    output logic [SIZEB-1:0]        core_b,
    output logic                    core_start,
    output logic                    core_clr,
    input  logic [SIZEA+SIZEB-1:0]  core_c,
    input  logic                    core_done
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int RES_W = SIZEA + SIZEB;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [SIZEA-1:0]   core_a_q, core_a_d;
    logic [SIZEB-1:0]   core_b_q, core_b_d;
    logic               core_start_q, core_start_d;
    logic               core_clr_q, core_clr_d;
    logic [NREQ-1:0]    ack_q, ack_d;
    logic [RES_W-1:0]   res_q, res_d;
    logic               res_err_q, res_err_d;
    logic               busy_q, busy_d;

    logic [NREQ-1:0]    pick_grant;
    logic [IDX_W-1:0]   pick_idx;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        sel_d        = sel_q;
        timer_d      = timer_q;
        core_a_d     = core_a_q;
        core_b_d     = core_b_q;
        core_start_d = core_start_q;
        core_clr_d   = 1'b0;
        ack_d        = '0;
        res_d        = res_q;
        res_err_d    = res_err_q;
        busy_d       = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (|pick_grant) begin
                    sel_d        = pick_idx;
                    core_a_d     = a_flat[pick_idx*SIZEA +: SIZEA];
                    core_b_d     = b_flat[pick_idx*SIZEB +: SIZEB];
                    core_start_d = 1'b1;
                    timer_d      = '0;
                    busy_d       = 1'b1;
                    state_d      = ST_RUN;
                end
            end
            ST_RUN: begin
                timer_d = timer_q + TMR_W'(1);
                // A completion on the last allowed cycle still counts as success.
                if (core_done || (timer_q == TMR_LAST)) begin
                    res_d        = core_done ? core_c : '0;
                    res_err_d    = ~core_done;
                    ack_d        = NREQ'(1) << sel_q;
                    core_start_d = 1'b0;
                    core_clr_d   = 1'b1;
                    state_d      = ST_CLR;
                end
            end
            ST_CLR: begin
                ptr_d   = (sel_q == IDX_W'(NREQ - 1)) ? '0 : sel_q + IDX_W'(1);
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            sel_q        <= '0;
            timer_q      <= '0;
            core_a_q     <= '0;
            core_b_q     <= '0;
            core_start_q <= 1'b0;
            core_clr_q   <= 1'b0;
            ack_q        <= '0;
            res_q        <= '0;
            res_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            sel_q        <= sel_d;
            timer_q      <= timer_d;
            core_a_q     <= core_a_d;
            core_b_q     <= core_b_d;
            core_start_q <= core_start_d;
            core_clr_q   <= core_clr_d;
            ack_q        <= ack_d;
            res_q        <= res_d;
            res_err_q    <= res_err_d;
            busy_q       <= busy_d;
        end
    end

    assign ack        = ack_q;
    assign res        = res_q;
    assign res_err    = res_err_q;
    assign busy       = busy_q;
    assign core_a     = core_a_q;
    assign core_b     = core_b_q;
    assign core_start = core_start_q;
    assign core_clr   = core_clr_q;

endmodule

// File: tb/tb_sbm_share_ctrl.sv
// Self-checking bench for sbm_share_ctrl with an 8-bit digit-serial multiplier core model.
module tb_sbm_share_ctrl;

    localparam int NREQ = 4;
    localparam int SA   = 16;
    localparam int SB   = 16;
    localparam int TO   = 64;
    localparam int RW   = SA + SB;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [NREQ*SA-1:0] a_flat = '0;
    logic [NREQ*SB-1:0] b_flat = '0;
    logic [NREQ-1:0] ack;
    logic [RW-1:0]   res;
    logic            res_err;
    logic            busy;
    logic [SA-1:0]   core_a;
    logic [SB-1:0]   core_b;
    logic            core_start;
    logic            core_clr;
    logic [RW-1:0]   core_c;
    logic            core_done;

    sbm_share_ctrl #(.NREQ(NREQ), .SIZEA(SA), .SIZEB(SB), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .a_flat     (a_flat),
        .b_flat     (b_flat),
        .ack        (ack),
        .res        (res),
        .res_err    (res_err),
        .busy       (busy),
        .core_a     (core_a),
        .core_b     (core_b),
        .core_start (core_start),
        .core_clr   (core_clr),
        .core_c     (core_c),
        .core_done  (core_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Core model: two 8-bit digits of B, then holds done until cleared.
    int         core_lat  = 2;
    bit         core_hang = 1'b0;
    logic [7:0] cnt;
    logic [31:0] acc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            acc       <= '0;
            core_done <= 1'b0;
        end else if (core_clr) begin
            cnt       <= '0;
            acc       <= '0;
            core_done <= 1'b0;
        end else if (core_start && !core_done && !core_hang) begin
            if (cnt == 8'd0)
                acc <= 32'(core_a) * 32'(core_b[7:0]);
            else if (cnt == 8'd1)
                acc <= acc + ((32'(core_a) * 32'(core_b[15:8])) << 8);
            cnt <= cnt + 8'd1;
            if (int'(cnt) + 1 == core_lat)
                core_done <= 1'b1;
        end
    end

    assign core_c = core_done ? acc : 32'hDEAD_BEEF;

    typedef struct {
        logic [NREQ-1:0] ack;
        logic [RW-1:0]   res;
        logic            err;
        int              lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   start_cyc = 0;
    logic prev_start = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (core_start && !prev_start)
            start_cyc = cyc;
        prev_start = core_start;
        if (ack != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 64'(ack), 64'(0));
            end else begin
                mon_e = sb.pop_front();
                $display("txn: ack=%b res=%h res_err=%b latency=%0d", ack, res, res_err,
                         cyc - start_cyc);
                check("ack",      64'(ack),             64'(mon_e.ack));
                check("res",      64'(res),             64'(mon_e.res));
                check("res_err",  64'(res_err),         64'(mon_e.err));
                check("core_clr", 64'(core_clr),        64'(1));
                check("latency",  64'(cyc - start_cyc), 64'(mon_e.lat));
            end
        end
    end

    task automatic set_ops(input int i, input logic [SA-1:0] a, input logic [SB-1:0] b);
        a_flat[i*SA +: SA] = a;
        b_flat[i*SB +: SB] = b;
    endtask

    task automatic push_exp(input int i, input logic [RW-1:0] r, input logic e, input int lat);
        exp_t x;
        x.ack = NREQ'(1) << i;
        x.res = r;
        x.err = e;
        x.lat = lat;
        sb.push_back(x);
    endtask

    task automatic wait_ack(input int i, input bit drop);
        int n;
        n = 0;
        while (ack[i] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300)
            check("ack_wait_timeout", 64'(0), 64'(1));
        if (drop) begin
            @(posedge clk);
            #1 req[i] = 1'b0;
        end
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (core_start !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50)
            check("start_wait_timeout", 64'(0), 64'(1));
    endtask

    typedef struct {
        int              idx;
        logic [SA-1:0]   a;
        logic [SB-1:0]   b;
        int              lat;
        bit              hang;
        logic [RW-1:0]   exp_res;
        logic            exp_err;
        int              exp_lat;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{0, 16'h00FF, 16'h0101,  2, 1'b0, 32'h0000_FFFF, 1'b0,  3};
        tbl[1] = '{1, 16'h1234, 16'h0010,  4, 1'b0, 32'h0001_2340, 1'b0,  5};
        tbl[2] = '{2, 16'hFFFF, 16'hFFFF,  3, 1'b0, 32'hFFFE_0001, 1'b0,  4};
        tbl[3] = '{3, 16'h8000, 16'h0002,  2, 1'b1, 32'h0000_0000, 1'b1, 64};
        tbl[4] = '{3, 16'h0003, 16'h0005,  2, 1'b0, 32'h0000_000F, 1'b0,  3};
        tbl[5] = '{0, 16'hABCD, 16'h0001, 63, 1'b0, 32'h0000_ABCD, 1'b0, 64};
        tbl[6] = '{2, 16'h0100, 16'h0100,  2, 1'b0, 32'h0001_0000, 1'b0,  3};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ack",        64'(ack),        64'(0));
        check("rst_res",        64'(res),        64'(0));
        check("rst_res_err",    64'(res_err),    64'(0));
        check("rst_busy",       64'(busy),       64'(0));
        check("rst_core_start", 64'(core_start), 64'(0));
        check("rst_core_clr",   64'(core_clr),   64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Contention from reset: 0,1,2,3 then 0 again with all requests held
        for (int i = 0; i < NREQ; i++)
            set_ops(i, 16'h1000 + 16'(i * 16'h0111), 16'h0203 + 16'(i));
        core_lat = 2;
        for (int k = 0; k < 5; k++) begin
            int w;
            w = k % NREQ;
            push_exp(w, 32'(16'h1000 + 16'(w * 16'h0111)) * 32'(16'h0203 + 16'(w)), 1'b0, 3);
        end
        req = 4'b1111;
        @(negedge clk);
        check("busy_run",   64'(busy),       64'(1));
        check("start_run",  64'(core_start), 64'(1));
        check("core_a_win", 64'(core_a),     64'(16'h1000));
        wait_ack(0, 1'b0);
        wait_ack(1, 1'b0);
        wait_ack(2, 1'b0);
        wait_ack(3, 1'b0);
        wait_ack(0, 1'b0);
        @(posedge clk);
        #1 req = '0;
        repeat (3) @(negedge clk);
        check("busy_idle", 64'(busy), 64'(0));

        // Table: single jobs, timeout, recovery, done exactly at timeout
        for (int t = 0; t < 7; t++) begin
            core_lat  = tbl[t].lat;
            core_hang = tbl[t].hang;
            set_ops(tbl[t].idx, tbl[t].a, tbl[t].b);
            push_exp(tbl[t].idx, tbl[t].exp_res, tbl[t].exp_err, tbl[t].exp_lat);
            req[tbl[t].idx] = 1'b1;
            wait_ack(tbl[t].idx, 1'b1);
            @(negedge clk);
            check("res_hold",     64'(res),     64'(tbl[t].exp_res));
            check("res_err_hold", 64'(res_err), 64'(tbl[t].exp_err));
            core_hang = 1'b0;
        end

        // Reset mid-job: pointer would favour 3 afterwards unless reset clears it
        set_ops(3, 16'h1111, 16'h2222);
        core_lat = 20;
        req[3] = 1'b1;
        wait_start();
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ack",        64'(ack),        64'(0));
        check("mid_rst_res",        64'(res),        64'(0));
        check("mid_rst_busy",       64'(busy),       64'(0));
        check("mid_rst_core_start", 64'(core_start), 64'(0));
        check("mid_rst_core_a",     64'(core_a),     64'(0));
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        core_lat = 2;
        set_ops(2, 16'h0011, 16'h0022);
        set_ops(3, 16'h0033, 16'h0044);
        push_exp(2, 32'h0000_0242, 1'b0, 3);
        push_exp(3, 32'h0000_0D8C, 1'b0, 3);
        req = 4'b1100;
        wait_ack(2, 1'b1);
        wait_ack(3, 1'b1);

        // Operand isolation: change requester 1 operands while its job runs
        set_ops(1, 16'h0077, 16'h0100);
        core_lat = 10;
        push_exp(1, 32'h0000_7700, 1'b0, 11);
        @(negedge clk);
        req[1] = 1'b1;
        wait_start();
        set_ops(1, 16'hFFFF, 16'hFFFF);
        @(negedge clk);
        check("core_a_latched", 64'(core_a), 64'(16'h0077));
        wait_ack(1, 1'b1);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
